// File: rtl/cmos_i2c_arbiter_if.sv
// cmos_i2c_arbiter_if: requester and driver bundle for the
// camera I2C arbiter. master = requester/driver side.
`timescale 1ns/1ps
interface cmos_i2c_arbiter_if #(
   parameter int ADDR_W = 16
);
   logic              req0_valid;
   logic              req0_rh_wl;
   logic [ADDR_W-1:0] req0_addr;
   logic [7:0]        req0_wdata;
   logic              req0_grant;
   logic              req0_done;
   logic [7:0]        req0_rdata;
   logic              req0_err;

   logic              req1_valid;
   logic              req1_rh_wl;
   logic [ADDR_W-1:0] req1_addr;
   logic [7:0]        req1_wdata;
   logic              req1_grant;
   logic              req1_done;
   logic [7:0]        req1_rdata;
   logic              req1_err;

   logic              drv_exec;
   logic              drv_rh_wl;
   logic [ADDR_W-1:0] drv_addr;
   logic [7:0]        drv_wdata;
   logic              drv_done;
   logic              drv_ack;
   logic [7:0]        drv_rdata;

   logic              busy;
   logic              owner;
   logic              timeout_evt;

   modport master (
      output req0_valid, req0_rh_wl,
      output req0_addr, req0_wdata,
      input  req0_grant, req0_done,
      input  req0_rdata, req0_err,
      output req1_valid, req1_rh_wl,
      output req1_addr, req1_wdata,
      input  req1_grant, req1_done,
      input  req1_rdata, req1_err,
      input  drv_exec, drv_rh_wl,
      input  drv_addr, drv_wdata,
      output drv_done, drv_ack, drv_rdata,
      input  busy, owner, timeout_evt
   );

   modport slave (
      input  req0_valid, req0_rh_wl,
      input  req0_addr, req0_wdata,
      output req0_grant, req0_done,
      output req0_rdata, req0_err,
      input  req1_valid, req1_rh_wl,
      input  req1_addr, req1_wdata,
      output req1_grant, req1_done,
      output req1_rdata, req1_err,
      output drv_exec, drv_rh_wl,
      output drv_addr, drv_wdata,
      input  drv_done, drv_ack, drv_rdata,
      output busy, owner, timeout_evt
   );
endinterface

// File: rtl/cmos_i2c_arbiter.sv
// cmos_i2c_arbiter: shares one camera I2C driver between the
// config sequencer (req0) and the runtime access port (req1).
`timescale 1ns/1ps
module cmos_i2c_arbiter #(
   parameter int          PRIORITY_MODE = 0,
   parameter logic [15:0] TIMEOUT_CYC   = 16'd60000,
   parameter int          ADDR_W        = 16
) (
   input logic               clk,
   input logic               rst_n,
   cmos_i2c_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic        RR_MODE = (PRIORITY_MODE == 1);
   localparam logic [15:0] TO_LAST = TIMEOUT_CYC - 16'd1;

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              rr_q, rr_d;
   logic              owner_q, owner_d;
   logic              rh_wl_q, rh_wl_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              exec_q, exec_d;
   logic              grant0_q, grant0_d;
   logic              grant1_q, grant1_d;
   logic              done0_q, done0_d;
   logic              done1_q, done1_d;
   logic [7:0]        rdata0_q, rdata0_d;
   logic [7:0]        rdata1_q, rdata1_d;
   logic              err0_q, err0_d;
   logic              err1_q, err1_d;
   logic              tevt_q, tevt_d;
   logic              pick1;

   // rr_q=1 means req1 is preferred on the next tie
   assign pick1 = bus.req1_valid &
                  (~bus.req0_valid | (RR_MODE & rr_q));

   // next-state and output computation
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_d     = rr_q;
      owner_d  = owner_q;
      rh_wl_d  = rh_wl_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      err0_d   = err0_q;
      err1_d   = err1_q;
      exec_d   = 1'b0;
      grant0_d = 1'b0;
      grant1_d = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      tevt_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req0_valid | bus.req1_valid) begin
               state_d  = S_ISSUE;
               exec_d   = 1'b1;
               owner_d  = pick1;
               rr_d     = ~pick1;
               grant0_d = ~pick1;
               grant1_d = pick1;
               if (pick1) begin
                  rh_wl_d = bus.req1_rh_wl;
                  addr_d  = bus.req1_addr;
                  wdata_d = bus.req1_wdata;
               end else begin
                  rh_wl_d = bus.req0_rh_wl;
                  addr_d  = bus.req0_addr;
                  wdata_d = bus.req0_wdata;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            cnt_d   = 16'd0;
         end
         S_WAIT: begin
            if (bus.drv_done) begin
               state_d = S_RESP;
               if (owner_q) begin
                  rdata1_d = bus.drv_rdata;
                  err1_d   = bus.drv_ack;
                  done1_d  = 1'b1;
               end else begin
                  rdata0_d = bus.drv_rdata;
                  err0_d   = bus.drv_ack;
                  done0_d  = 1'b1;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d = S_RESP;
               tevt_d  = 1'b1;
               if (owner_q) begin
                  rdata1_d = 8'h00;
                  err1_d   = 1'b1;
                  done1_d  = 1'b1;
               end else begin
                  rdata0_d = 8'h00;
                  err0_d   = 1'b1;
                  done0_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 16'd0;
         rr_q     <= 1'b0;
         owner_q  <= 1'b0;
         rh_wl_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 8'h00;
         exec_q   <= 1'b0;
         grant0_q <= 1'b0;
         grant1_q <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         rdata0_q <= 8'h00;
         rdata1_q <= 8'h00;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         tevt_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rr_q     <= rr_d;
         owner_q  <= owner_d;
         rh_wl_q  <= rh_wl_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         exec_q   <= exec_d;
         grant0_q <= grant0_d;
         grant1_q <= grant1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
         tevt_q   <= tevt_d;
      end
   end

   assign bus.req0_grant  = grant0_q;
   assign bus.req0_done   = done0_q;
   assign bus.req0_rdata  = rdata0_q;
   assign bus.req0_err    = err0_q;
   assign bus.req1_grant  = grant1_q;
   assign bus.req1_done   = done1_q;
   assign bus.req1_rdata  = rdata1_q;
   assign bus.req1_err    = err1_q;
   assign bus.drv_exec    = exec_q;
   assign bus.drv_rh_wl   = rh_wl_q;
   assign bus.drv_addr    = addr_q;
   assign bus.drv_wdata   = wdata_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.owner       = owner_q;
   assign bus.timeout_evt = tevt_q;

endmodule

// File: tb/tb_cmos_i2c_arbiter.sv
// tb_cmos_i2c_arbiter: directed vectors for the camera I2C
// arbiter, fixed-priority (dut0) and round-robin (dut1).
`timescale 1ns/1ps
module tb_cmos_i2c_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   cmos_i2c_arbiter_if #(.ADDR_W(16)) ba ();
   cmos_i2c_arbiter_if #(.ADDR_W(16)) bb ();

   assign bb.req0_valid = ba.req0_valid;
   assign bb.req0_rh_wl = ba.req0_rh_wl;
   assign bb.req0_addr  = ba.req0_addr;
   assign bb.req0_wdata = ba.req0_wdata;
   assign bb.req1_valid = ba.req1_valid;
   assign bb.req1_rh_wl = ba.req1_rh_wl;
   assign bb.req1_addr  = ba.req1_addr;
   assign bb.req1_wdata = ba.req1_wdata;
   assign bb.drv_done   = ba.drv_done;
   assign bb.drv_ack    = ba.drv_ack;
   assign bb.drv_rdata  = ba.drv_rdata;

   cmos_i2c_arbiter #(
      .PRIORITY_MODE(0),
      .TIMEOUT_CYC(16'd100),
      .ADDR_W(16)
   ) dut0 (
      .clk(clk),
      .rst_n(rst_n),
      .bus(ba.slave)
   );

   cmos_i2c_arbiter #(
      .PRIORITY_MODE(1),
      .TIMEOUT_CYC(16'd100),
      .ADDR_W(16)
   ) dut1 (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bb.slave)
   );

   // pulse counters and grant order, sampled on the active edge
   int exec_a = 0;
   int tevt_a = 0;
   int dn_a[2] = '{0, 0};
   int qa[$];
   int qb[$];
   always @(posedge clk) begin
      exec_a = exec_a + int'(ba.drv_exec);
      tevt_a = tevt_a + int'(ba.timeout_evt);
      dn_a[0] = dn_a[0] + int'(ba.req0_done);
      dn_a[1] = dn_a[1] + int'(ba.req1_done);
      if (ba.req0_grant) qa.push_back(0);
      if (ba.req1_grant) qa.push_back(1);
      if (bb.req0_grant) qb.push_back(0);
      if (bb.req1_grant) qb.push_back(1);
   end

   typedef struct {
      bit         r;
      bit         rw;
      logic [15:0] addr;
      logic [7:0] wd;
      int         dly;
      bit         ack;
      logic [7:0] drd;
      bit         e_err;
      logic [7:0] e_rd;
      bit         e_tevt;
   } vec_t;

   vec_t tbl[7];
   logic [7:0] m_rd[2];
   bit         m_er[2];

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] outs_a();
      return {ba.req0_grant, ba.req0_done, ba.req0_rdata,
              ba.req0_err, ba.req1_grant, ba.req1_done,
              ba.req1_rdata, ba.req1_err, ba.drv_exec,
              ba.drv_rh_wl, ba.drv_addr, ba.drv_wdata,
              ba.busy, ba.owner, ba.timeout_evt};
   endfunction

   function automatic logic [63:0] outs_b();
      return {bb.req0_grant, bb.req0_done, bb.req0_rdata,
              bb.req0_err, bb.req1_grant, bb.req1_done,
              bb.req1_rdata, bb.req1_err, bb.drv_exec,
              bb.drv_rh_wl, bb.drv_addr, bb.drv_wdata,
              bb.busy, bb.owner, bb.timeout_evt};
   endfunction

   function automatic bit gnt_a(input bit r);
      return r ? ba.req1_grant : ba.req0_grant;
   endfunction
   function automatic bit done_a(input bit r);
      return r ? ba.req1_done : ba.req0_done;
   endfunction
   function automatic bit done_b(input bit r);
      return r ? bb.req1_done : bb.req0_done;
   endfunction
   function automatic logic [7:0] rd_a(input bit r);
      return r ? ba.req1_rdata : ba.req0_rdata;
   endfunction
   function automatic logic [7:0] rd_b(input bit r);
      return r ? bb.req1_rdata : bb.req0_rdata;
   endfunction
   function automatic bit er_a(input bit r);
      return r ? ba.req1_err : ba.req0_err;
   endfunction
   function automatic bit er_b(input bit r);
      return r ? bb.req1_err : bb.req0_err;
   endfunction

   task automatic set_req(input bit r, input bit v,
                          input bit rw,
                          input logic [15:0] a,
                          input logic [7:0] d);
      if (r) begin
         ba.req1_valid = v;
         ba.req1_rh_wl = rw;
         ba.req1_addr  = a;
         ba.req1_wdata = d;
      end else begin
         ba.req0_valid = v;
         ba.req0_rh_wl = rw;
         ba.req0_addr  = a;
         ba.req0_wdata = d;
      end
   endtask

   // one transaction: dly=0 means the driver never answers
   task automatic run_txn(input vec_t v, input string nm);
      int  e0, t0, d0, d1;
      bit  got;
      bit  o;
      o  = ~v.r;
      e0 = exec_a;
      t0 = tevt_a;
      d0 = dn_a[v.r];
      d1 = dn_a[o];
      set_req(v.r, 1'b1, v.rw, v.addr, v.wd);
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (gnt_a(v.r)) got = 1'b1;
      end
      chk({nm, "_grant"}, got, 1);
      set_req(v.r, 1'b0, v.rw, v.addr, v.wd);
      if (!got) return;
      chk({nm, "_exec"}, ba.drv_exec, 1);
      chk({nm, "_addr"}, ba.drv_addr, v.addr);
      chk({nm, "_wdata"}, ba.drv_wdata, v.wd);
      chk({nm, "_rhwl"}, ba.drv_rh_wl, v.rw);
      chk({nm, "_owner"}, ba.owner, v.r);
      if (v.dly == 0) begin
         repeat (100) @(negedge clk);
         chk({nm, "_tevt_early"}, ba.timeout_evt, 0);
         chk({nm, "_busy_c99"}, ba.busy, 1);
         @(negedge clk);
      end else begin
         repeat (v.dly) @(negedge clk);
         ba.drv_done  = 1'b1;
         ba.drv_ack   = v.ack;
         ba.drv_rdata = v.drd;
         @(negedge clk);
         ba.drv_done  = 1'b0;
         ba.drv_ack   = 1'b0;
         ba.drv_rdata = 8'h00;
      end
      chk({nm, "_done"}, done_a(v.r), 1);
      chk({nm, "_err"}, er_a(v.r), v.e_err);
      chk({nm, "_rdata"}, rd_a(v.r), v.e_rd);
      chk({nm, "_tevt"}, ba.timeout_evt, v.e_tevt);
      chk({nm, "_b_done"}, done_b(v.r), 1);
      chk({nm, "_b_err"}, er_b(v.r), v.e_err);
      chk({nm, "_b_rdata"}, rd_b(v.r), v.e_rd);
      chk({nm, "_oth_done"}, done_a(o), 0);
      chk({nm, "_oth_err"}, er_a(o), m_er[o]);
      chk({nm, "_oth_rdata"}, rd_a(o), m_rd[o]);
      chk({nm, "_addr_hold"}, ba.drv_addr, v.addr);
      m_er[v.r] = v.e_err;
      m_rd[v.r] = v.e_rd;
      @(negedge clk);
      chk({nm, "_idle"}, ba.busy, 0);
      chk({nm, "_exec_cnt"}, exec_a - e0, 1);
      chk({nm, "_done_cnt"}, dn_a[v.r] - d0, 1);
      chk({nm, "_oth_cnt"}, dn_a[o] - d1, 0);
      chk({nm, "_tevt_cnt"}, tevt_a - t0, int'(v.e_tevt));
   endtask

   initial begin
      int  qa0, qb0, d0, d1, e0;
      bit  got;
      ba.req0_valid = 1'b0;
      ba.req0_rh_wl = 1'b0;
      ba.req0_addr  = 16'h0;
      ba.req0_wdata = 8'h0;
      ba.req1_valid = 1'b0;
      ba.req1_rh_wl = 1'b0;
      ba.req1_addr  = 16'h0;
      ba.req1_wdata = 8'h0;
      ba.drv_done   = 1'b0;
      ba.drv_ack    = 1'b0;
      ba.drv_rdata  = 8'h0;
      m_rd[0] = 8'h00;
      m_rd[1] = 8'h00;
      m_er[0] = 1'b0;
      m_er[1] = 1'b0;

      //        r  rw addr      wd     dly ack drd  err rd  tevt
      tbl[0] = '{1'b0, 1'b0, 16'h3E01, 8'h4A, 20,
                 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 16'h3107, 8'h00, 5,
                 1'b0, 8'h21, 1'b0, 8'h21, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 16'h3503, 8'h10, 3,
                 1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 16'h5000, 8'h00, 0,
                 1'b0, 8'hEE, 1'b1, 8'h00, 1'b1};
      tbl[4] = '{1'b1, 1'b1, 16'h3A0F, 8'h00, 100,
                 1'b1, 8'h77, 1'b1, 8'h77, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 16'h300A, 8'h00, 1,
                 1'b0, 8'h56, 1'b0, 8'h56, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 16'h3500, 8'h33, 100,
                 1'b0, 8'h12, 1'b0, 8'h12, 1'b0};

      repeat (2) @(negedge clk);
      chk("reset_outs_a", outs_a(), 64'h0);
      chk("reset_outs_b", outs_b(), 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", ba.busy, 0);

      for (int i = 0; i < 7; i++)
         run_txn(tbl[i], $sformatf("v%0d", i));

      // both requesters held valid for three grants
      qa0 = qa.size();
      qb0 = qb.size();
      d1  = dn_a[1];
      set_req(1'b0, 1'b1, 1'b0, 16'h3000, 8'h01);
      set_req(1'b1, 1'b1, 1'b0, 16'h3100, 8'h02);
      for (int k = 0; k < 3; k++) begin
         got = 1'b0;
         for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ba.req0_grant | ba.req1_grant) got = 1'b1;
         end
         chk($sformatf("cont_grant%0d", k), got, 1);
         @(negedge clk);
         ba.drv_done = 1'b1;
         @(negedge clk);
         ba.drv_done = 1'b0;
         if (k == 2) begin
            set_req(1'b0, 1'b0, 1'b0, 16'h3000, 8'h01);
            set_req(1'b1, 1'b0, 1'b0, 16'h3100, 8'h02);
         end
      end
      repeat (3) @(negedge clk);
      chk("cont_idle", ba.busy, 0);
      chk("cont_na", qa.size() - qa0, 3);
      chk("cont_nb", qb.size() - qb0, 3);
      if (qa.size() >= qa0 + 3 && qb.size() >= qb0 + 3) begin
         chk("fixed_g0", qa[qa0], 0);
         chk("fixed_g1", qa[qa0 + 1], 0);
         chk("fixed_g2", qa[qa0 + 2], 0);
         chk("rr_g0", qb[qb0], 0);
         chk("rr_g1", qb[qb0 + 1], 1);
         chk("rr_g2", qb[qb0 + 2], 0);
      end
      chk("fixed_starve", dn_a[1] - d1, 0);

      // reset in the middle of WAIT
      set_req(1'b1, 1'b1, 1'b1, 16'h3200, 8'h00);
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (ba.req1_grant) got = 1'b1;
      end
      chk("rst_grant", got, 1);
      set_req(1'b1, 1'b0, 1'b1, 16'h3200, 8'h00);
      repeat (5) @(negedge clk);
      chk("rst_busy_before", ba.busy, 1);
      d0 = dn_a[0];
      d1 = dn_a[1];
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_outs_a", outs_a(), 64'h0);
      chk("rst_outs_b", outs_b(), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_after_a", outs_a(), 64'h0);
      chk("rst_no_done", (dn_a[0] - d0) + (dn_a[1] - d1), 0);
      m_rd[0] = 8'h00;
      m_rd[1] = 8'h00;
      m_er[0] = 1'b0;
      m_er[1] = 1'b0;

      // stray driver completion while idle
      d0 = dn_a[0];
      d1 = dn_a[1];
      e0 = exec_a;
      ba.drv_done  = 1'b1;
      ba.drv_ack   = 1'b1;
      ba.drv_rdata = 8'hA5;
      @(negedge clk);
      ba.drv_done  = 1'b0;
      ba.drv_ack   = 1'b0;
      ba.drv_rdata = 8'h00;
      repeat (2) @(negedge clk);
      chk("stray_done_cnt", (dn_a[0] - d0) + (dn_a[1] - d1), 0);
      chk("stray_exec_cnt", exec_a - e0, 0);
      chk("stray_outs", outs_a(), 64'h0);

      // normal req1 after the reset
      run_txn('{1'b1, 1'b1, 16'h3300, 8'h00, 4,
                1'b0, 8'h9C, 1'b0, 8'h9C, 1'b0}, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
